placar_controle: RTL and testbench

Sequencing controller for the basketball scoreboard datapath. Conditions the three point buttons (1/2/3 points), holds the registered score of each team, and time-shares the single external 7-bit adder/subtractor between the two team score registers. Validates each result, commits it or rejects it with a timed buzzer pulse, and sits between the board inputs and the display decoders.

---
 rtl/placar_pkg.sv | 31 +++
 rtl/placar_botao.sv | 70 +++++++
 rtl/placar_controle.sv | 179 +++++++++++++++++
 tb/tb_placar_controle.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/placar_pkg.sv
// placar_pkg: shared types and constants for the scoreboard controller.
//   estado_t          - controller FSM states
//   PONTO1..PONTO3    - point values of buttons A, B and C
//   PONTOS_W          - width of a team score (7 bits, holds 0..99)
//   codifica_pontos() - priority encoder over same-cycle presses (C > B > A)
package placar_pkg;

  localparam int PONTOS_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    CARREGA,
    VERIFICA,
    BUZINA
  } estado_t;

  localparam logic [1:0] PONTO1 = 2'd1;
  localparam logic [1:0] PONTO2 = 2'd2;
  localparam logic [1:0] PONTO3 = 2'd3;

  // Returns 0 when no button was pressed.
  function automatic logic [1:0] codifica_pontos(input logic a, input logic b, input logic c);
    logic [1:0] v;
    v = 2'd0;
    if (c) v = PONTO3;
    else if (b) v = PONTO2;
    else if (a) v = PONTO1;
    return v;
  endfunction

endpackage

// File: rtl/placar_botao.sv
// placar_botao: conditions one raw push button into a single-cycle press pulse.
//   clk, rst_n  - clock, asynchronous active-low reset
//   btn         - raw asynchronous active-high button
//   press       - one-cycle pulse on each accepted rising edge
// Macro PLACAR_DEBOUNCE_EN: when defined, the synchronised level must stay
// stable for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
module placar_botao #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("placar_botao: DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1;
  logic sync2;
  logic nivel;
  logic nivel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef PLACAR_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronised level disagrees with the
  // accepted one; any return to the accepted level restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == nivel) begin
      cnt <= '0;
    end else if (cnt == CNT_FIM) begin
      nivel <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign nivel = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      nivel_q <= nivel;
      press   <= nivel & ~nivel_q;
    end
  end

endmodule

// File: rtl/placar_controle.sv
// placar_controle: sequencing controller of the basketball scoreboard.
// Conditions the three point buttons, holds both team scores and time-shares
// the external 7-bit adder/subtractor to update them.
//   clk, rst_n            - clock, asynchronous active-low reset
//   btn_a/btn_b/btn_c     - raw buttons worth 1/2/3 points
//   chave_negativa        - 1 = subtract, 0 = add (sampled on accepted press)
//   mudar_time            - target team (sampled on accepted press)
//   zerar                 - synchronous clear of both scores, aborts any operation
//   alu_a/alu_b/alu_sub   - operands and subtract select to the external adder
//   alu_s/alu_cout        - adder result and carry-out (1 = no borrow when subtracting)
//   pontos_time0/1        - registered team scores
//   buzzer                - high for BUZZ_CYCLES after a rejected operation
//   led                   - one-cycle pulse when a result is committed
//   ocupado               - high while the FSM is not idle
// Macro PLACAR_DEBOUNCE_EN: enables the per-button debouncers in placar_botao.
module placar_controle
  import placar_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BUZZ_CYCLES     = 25000000,
  parameter int MAX_PONTOS      = 99
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_a,
  input  logic                btn_b,
  input  logic                btn_c,
  input  logic                chave_negativa,
  input  logic                mudar_time,
  input  logic                zerar,
  output logic [PONTOS_W-1:0] alu_a,
  output logic [PONTOS_W-1:0] alu_b,
  output logic                alu_sub,
  input  logic [PONTOS_W-1:0] alu_s,
  input  logic                alu_cout,
  output logic [PONTOS_W-1:0] pontos_time0,
  output logic [PONTOS_W-1:0] pontos_time1,
  output logic                buzzer,
  output logic                led,
  output logic                ocupado
);

  localparam int BUZZ_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
  localparam logic [BUZZ_W-1:0]   BUZZ_FIM = BUZZ_W'(BUZZ_CYCLES - 1);
  localparam logic [PONTOS_W-1:0] MAX_P    = PONTOS_W'(MAX_PONTOS);

  logic press_a, press_b, press_c;

  placar_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_botao_a (
    .clk(clk), .rst_n(rst_n), .btn(btn_a), .press(press_a)
  );
  placar_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_botao_b (
    .clk(clk), .rst_n(rst_n), .btn(btn_b), .press(press_b)
  );
  placar_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_botao_c (
    .clk(clk), .rst_n(rst_n), .btn(btn_c), .press(press_c)
  );

  estado_t           estado, prox;
  logic [1:0]        valor;
  logic [1:0]        op_pontos;
  logic              op_neg;
  logic              op_time;
  logic [BUZZ_W-1:0] buzz_cnt;
  logic              carrega_op;
  logic              commit;
  logic              inicia_buzz;
  logic              valido;

  assign valor = codifica_pontos(press_a, press_b, press_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= prox;
  end

  // zerar overrides everything decided here, including a same-cycle commit.
  always_comb begin
    prox        = estado;
    carrega_op  = 1'b0;
    commit      = 1'b0;
    inicia_buzz = 1'b0;
    valido      = 1'b0;
    case (estado)
      IDLE: begin
        if (valor != 2'd0) begin
          prox       = CARREGA;
          carrega_op = 1'b1;
        end
      end
      CARREGA: prox = VERIFICA;
      VERIFICA: begin
        // Add overflows on carry-out or beyond the two-digit limit;
        // subtract underflows when there is a borrow (carry-out low).
        valido = op_neg ? alu_cout : (!alu_cout && (alu_s <= MAX_P));
        if (valido) begin
          commit = 1'b1;
          prox   = IDLE;
        end else begin
          inicia_buzz = 1'b1;
          prox        = BUZINA;
        end
      end
      BUZINA: begin
        if (buzz_cnt == '0) prox = IDLE;
      end
      default: prox = IDLE;
    endcase
    if (zerar) begin
      prox        = IDLE;
      carrega_op  = 1'b0;
      commit      = 1'b0;
      inicia_buzz = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_pontos <= 2'd0;
      op_neg    <= 1'b0;
      op_time   <= 1'b0;
    end else if (carrega_op) begin
      op_pontos <= valor;
      op_neg    <= chave_negativa;
      op_time   <= mudar_time;
    end
  end

  // Loaded with BUZZ_CYCLES-1 so BUZINA lasts exactly BUZZ_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzz_cnt <= '0;
    end else if (zerar) begin
      buzz_cnt <= '0;
    end else if (inicia_buzz) begin
      buzz_cnt <= BUZZ_FIM;
    end else if (estado == BUZINA && buzz_cnt != '0) begin
      buzz_cnt <= buzz_cnt - 1'b1;
    end
  end

  // Operands are driven only during VERIFICA; zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sub <= 1'b0;
    end else if (estado == CARREGA && !zerar) begin
      alu_a   <= op_time ? pontos_time1 : pontos_time0;
      alu_b   <= {{(PONTOS_W-2){1'b0}}, op_pontos};
      alu_sub <= op_neg;
    end else begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sub <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pontos_time0 <= '0;
      pontos_time1 <= '0;
      led          <= 1'b0;
    end else begin
      led <= commit;
      if (zerar) begin
        pontos_time0 <= '0;
        pontos_time1 <= '0;
      end else if (commit) begin
        if (op_time) pontos_time1 <= alu_s;
        else         pontos_time0 <= alu_s;
      end
    end
  end

  assign buzzer  = (estado == BUZINA);
  assign ocupado = (estado != IDLE);

endmodule

// File: tb/tb_placar_controle.sv
module tb_placar_controle;

  localparam int D   = 4;
  localparam int BZ  = 8;
  localparam int MAX = 99;
`ifdef PLACAR_DEBOUNCE_EN
  localparam int DEB_ON = 1;
`else
  localparam int DEB_ON = 0;
`endif
  localparam int DX     = DEB_ON ? D : 0;
  localparam int HOLD   = DX + 3;
  localparam int SETTLE = 25 + DX;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_a, btn_b, btn_c;
  logic       chave_negativa, mudar_time, zerar;
  logic [6:0] alu_a, alu_b, alu_s;
  logic       alu_sub, alu_cout;
  logic [6:0] pontos_time0, pontos_time1;
  logic       buzzer, led, ocupado;
  logic [7:0] soma;

  placar_controle #(.DEBOUNCE_CYCLES(D), .BUZZ_CYCLES(BZ), .MAX_PONTOS(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
    .chave_negativa(chave_negativa), .mudar_time(mudar_time), .zerar(zerar),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
    .alu_s(alu_s), .alu_cout(alu_cout),
    .pontos_time0(pontos_time0), .pontos_time1(pontos_time1),
    .buzzer(buzzer), .led(led), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // External adder/subtractor: A + ~B + 1 when subtracting.
  always_comb begin
    if (alu_sub) soma = {1'b0, alu_a} + {1'b0, ~alu_b} + 8'd1;
    else         soma = {1'b0, alu_a} + {1'b0, alu_b};
  end
  assign alu_s    = soma[6:0];
  assign alu_cout = soma[7];

  int vectors    = 0;
  int miscompares = 0;
  int ciclo      = 0;

  // ---------------- behavioural model ----------------
  // t: cycles since the accepted press (0 = idle), op_*: the operation in flight.
  int m_p[2];
  int t;
  int op_team, op_pts;
  bit op_neg;
  bit m_led;
  bit d1[3];
  bit run_val[3];
  int run_len[3];
  bit lvl1[3], lvl2[3];
  bit prs[3];
  bit bnow[3];
  int pts_in;
  bit s_now, l_now;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p[0] = 0; m_p[1] = 0; t = 0; m_led = 0;
      op_team = 0; op_pts = 0; op_neg = 0;
      for (int i = 0; i < 3; i++) begin
        d1[i] = 0; run_val[i] = 0; run_len[i] = 0;
        lvl1[i] = 0; lvl2[i] = 0; prs[i] = 0;
      end
    end else begin
      pts_in = prs[2] ? 3 : prs[1] ? 2 : prs[0] ? 1 : 0;
      m_led = 0;
      if (zerar) begin
        m_p[0] = 0; m_p[1] = 0; t = 0;
      end else if (t == 0) begin
        if (pts_in != 0) begin
          op_pts = pts_in; op_neg = chave_negativa; op_team = int'(mudar_time); t = 1;
        end
      end else if (t == 1) begin
        t = 2;
      end else if (t == 2) begin
        if (op_neg ? (m_p[op_team] >= op_pts) : (m_p[op_team] + op_pts <= MAX)) begin
          m_p[op_team] = op_neg ? m_p[op_team] - op_pts : m_p[op_team] + op_pts;
          m_led = 1; t = 0;
        end else begin
          t = 3;
        end
      end else begin
        t = (t == 2 + BZ) ? 0 : t + 1;
      end
      // button chain: two-cycle synchroniser delay, optional stability filter,
      // then a registered rising-edge pulse.
      bnow[0] = btn_a; bnow[1] = btn_b; bnow[2] = btn_c;
      for (int i = 0; i < 3; i++) begin
        s_now = d1[i];
        d1[i] = bnow[i];
        if (DEB_ON != 0) l_now = (run_len[i] >= D) ? run_val[i] : lvl1[i];
        else             l_now = s_now;
        if (s_now == run_val[i]) begin
          if (run_len[i] < 1000) run_len[i] = run_len[i] + 1;
        end else begin
          run_val[i] = s_now; run_len[i] = 1;
        end
        prs[i]  = lvl1[i] & ~lvl2[i];
        lvl2[i] = lvl1[i];
        lvl1[i] = l_now;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [6:0] e_a, e_b;
  logic       e_sub, e_buz, e_ocp;
  always @(negedge clk) begin
    ciclo++;
    e_a   = (t == 2) ? 7'(m_p[op_team]) : 7'd0;
    e_b   = (t == 2) ? 7'(op_pts) : 7'd0;
    e_sub = (t == 2) ? op_neg : 1'b0;
    e_buz = (t >= 3);
    e_ocp = (t != 0);
    vectors++;
    if (pontos_time0 !== 7'(m_p[0]) || pontos_time1 !== 7'(m_p[1]) || led !== m_led ||
        buzzer !== e_buz || ocupado !== e_ocp || alu_a !== e_a || alu_b !== e_b || alu_sub !== e_sub) begin
      miscompares++;
      $display("FAIL cycle %0d: got p0=%0d p1=%0d led=%b buz=%b ocp=%b a=%0d b=%0d sub=%b; want p0=%0d p1=%0d led=%b buz=%b ocp=%b a=%0d b=%0d sub=%b",
               ciclo, pontos_time0, pontos_time1, led, buzzer, ocupado, alu_a, alu_b, alu_sub,
               m_p[0], m_p[1], m_led, e_buz, e_ocp, e_a, e_b, e_sub);
    end
  end

  int led_cnt = 0;
  int buz_cnt = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (led) led_cnt++;
      if (buzzer) buz_cnt++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] mask, input logic team, input logic neg);
    @(negedge clk);
    mudar_time = team; chave_negativa = neg;
    {btn_c, btn_b, btn_a} = mask;
    repeat (HOLD) @(negedge clk);
    {btn_c, btn_b, btn_a} = 3'b000;
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int l0, b0, w;

  initial begin
    rst_n = 1'b0;
    {btn_c, btn_b, btn_a} = 3'b000;
    chave_negativa = 1'b0; mudar_time = 1'b0; zerar = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_p0", int'(pontos_time0), 0);
    chk("reset_p1", int'(pontos_time1), 0);
    chk("reset_buzzer", int'(buzzer), 0);
    chk("reset_ocupado", int'(ocupado), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // team 0: +2
    l0 = led_cnt; b0 = buz_cnt;
    push(3'b010, 1'b0, 1'b0);
    chk("add_b_p0", int'(pontos_time0), 2);
    chk("add_b_led", led_cnt - l0, 1);
    chk("add_b_buzzer", buz_cnt - b0, 0);

    // team 1 up to 98, then +3 rejected
    for (int i = 0; i < 32; i++) push(3'b100, 1'b1, 1'b0);
    push(3'b010, 1'b1, 1'b0);
    chk("p1_98", int'(pontos_time1), 98);
    l0 = led_cnt; b0 = buz_cnt;
    push(3'b100, 1'b1, 1'b0);
    chk("overflow_p1", int'(pontos_time1), 98);
    chk("overflow_buzz_len", buz_cnt - b0, BZ);
    chk("overflow_led", led_cnt - l0, 0);

    // team 0 subtract: 2-1=1, 1-2 rejected, 1-1=0
    push(3'b001, 1'b0, 1'b1);
    chk("sub_p0_1", int'(pontos_time0), 1);
    b0 = buz_cnt;
    push(3'b010, 1'b0, 1'b1);
    chk("underflow_p0", int'(pontos_time0), 1);
    chk("underflow_buzz_len", buz_cnt - b0, BZ);
    push(3'b001, 1'b0, 1'b1);
    chk("sub_p0_0", int'(pontos_time0), 0);

    // clear, then team 1 to 10
    @(negedge clk); zerar = 1'b1;
    @(negedge clk); zerar = 1'b0;
    chk("zerar_p1", int'(pontos_time1), 0);
    for (int i = 0; i < 3; i++) push(3'b100, 1'b1, 1'b0);
    push(3'b001, 1'b1, 1'b0);
    chk("p1_10", int'(pontos_time1), 10);

    // A and C together (C wins), B one cycle later lands in CARREGA and is dropped
    @(negedge clk);
    mudar_time = 1'b1; chave_negativa = 1'b0;
    btn_a = 1'b1; btn_c = 1'b1;
    @(negedge clk);
    btn_b = 1'b1;
    repeat (HOLD) @(negedge clk);
    {btn_c, btn_b, btn_a} = 3'b000;
    repeat (SETTLE) @(negedge clk);
    chk("prio_p1_13", int'(pontos_time1), 13);

    // zerar coincides with the commit edge
    @(negedge clk);
    mudar_time = 1'b0; chave_negativa = 1'b0; btn_a = 1'b1;
    repeat (5 + DX) @(negedge clk);
    zerar = 1'b1;
    @(negedge clk);
    zerar = 1'b0;
    chk("zerar_commit_p0", int'(pontos_time0), 0);
    chk("zerar_commit_p1", int'(pontos_time1), 0);
    chk("zerar_commit_ocupado", int'(ocupado), 0);
    repeat (HOLD) @(negedge clk);
    btn_a = 1'b0;
    repeat (SETTLE) @(negedge clk);

    // reset in the middle of BUZINA
    push(3'b100, 1'b1, 1'b0);
    @(negedge clk);
    mudar_time = 1'b0; chave_negativa = 1'b1; btn_a = 1'b1;
    w = 0;
    while (buzzer !== 1'b1 && w < 100) begin
      @(negedge clk); w++;
    end
    chk("buzzer_rises", int'(w < 100), 1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_buzzer", int'(buzzer), 0);
    chk("rst_p1", int'(pontos_time1), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    btn_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SETTLE) @(negedge clk);

`ifdef PLACAR_DEBOUNCE_EN
    l0 = led_cnt;
    @(negedge clk);
    mudar_time = 1'b0; chave_negativa = 1'b0; btn_a = 1'b1;
    repeat (2) @(negedge clk);
    btn_a = 1'b0;
    repeat (SETTLE) @(negedge clk);
    chk("glitch_led", led_cnt - l0, 0);
    chk("glitch_p0", int'(pontos_time0), 0);
`endif

    // randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) {btn_c, btn_b, btn_a} = 3'($urandom);
      else                           {btn_c, btn_b, btn_a} = 3'b000;
      chave_negativa = ($urandom_range(0, 3) == 0);
      mudar_time     = 1'($urandom_range(0, 1));
      zerar          = ($urandom_range(0, 59) == 0);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      zerar = 1'b0;
    end
    {btn_c, btn_b, btn_a} = 3'b000;
    repeat (SETTLE) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
